// File: rtl/uart_cmd_proc_p.sv
// UART command processor: parses framed single/burst read/write packets from the PHY byte
// handshake, buffers burst write data until the CRC verifies, and drives the logic bus.
module uart_cmd_proc_p #(
    parameter int unsigned P_ADR_W           = 12,
    parameter int unsigned P_DATA_BYTES      = 2,
    parameter int unsigned P_MAX_BURST       = 256,
    parameter int unsigned P_TIMEOUT_CNT_MAX = 120_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_cmd_req,
    input  logic [7:0]                  uart_cmd_data,
    output logic                        uart_cmd_ack,
    output logic                        uart_rsp_req,
    output logic [7:0]                  uart_rsp_data,
    input  logic                        uart_rsp_ack,
    output logic [P_ADR_W-1:0]          logic_adr,
    output logic [8*P_DATA_BYTES-1:0]   logic_wr_data,
    output logic                        logic_wr_req,
    output logic                        logic_rd_req,
    input  logic                        logic_ack,
    input  logic [8*P_DATA_BYTES-1:0]   logic_rd_data,
    output logic [31:0]                 err_out,
    output logic                        err_req,
    input  logic                        err_ack
);

    localparam int unsigned P_ADR_BYTES = (P_ADR_W + 7) / 8;
    localparam int unsigned P_DATA_W    = 8 * P_DATA_BYTES;
    localparam int unsigned CNT_W       = $clog2(P_MAX_BURST + 1);
    localparam int unsigned IDX_W       = (P_MAX_BURST > 1) ? $clog2(P_MAX_BURST) : 1;
    localparam int unsigned BCNT_W      = 3;
    localparam int unsigned TMO_W       = 32;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_PID1, S_PID0, S_LEN, S_ADR, S_WR_DATA, S_WR_CRC,
        S_WR_COMMIT, S_STATUS, S_RD_HS, S_RD_DATA, S_RD_CRC
    } state_e;

    state_e              state_q, st_prev_q;
    logic                cmd_ack_q;
    logic                rsp_req_q, rsp_wait_q, rsp_ack_prev_q;
    logic [7:0]          rsp_data_q;
    logic                wr_req_q, rd_req_q, bus_wait_q, bus_ack_prev_q;
    logic [P_ADR_W-1:0]  adr_q;
    logic [P_DATA_W-1:0] wr_data_q, word_q;
    logic                is_burst_q, is_wr_q;
    logic [15:0]         len_q;
    logic [BCNT_W-1:0]   bcnt_q;
    logic [CNT_W-1:0]    wptr_q, rptr_q;
    logic [15:0]         crc_q;
    logic [7:0]          crc_hi_q, status_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic [31:0]         err_q;
    logic                err_req_q;
    logic [P_DATA_W-1:0] buf_q [P_MAX_BURST];

    logic                rx_vld, rx_state, rsp_idle, rsp_done, bus_idle, bus_done;
    logic                last_adr, last_dat, last_word_wr, last_word_rd;
    logic [15:0]         len_full, crc_upd;
    logic [7:0]          crc_byte;
    logic [P_DATA_W-1:0] word_nxt;
    logic                len_err, crc_err, tmo_hit, buf_we;
    logic [31:0]         err_set;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Handshake and field decode helpers
    always_comb begin
        rx_vld       = cmd_ack_q & ~uart_cmd_req;
        rx_state     = state_q inside {S_IDLE, S_HDR0, S_PID1, S_PID0, S_LEN, S_ADR,
                                       S_WR_DATA, S_WR_CRC};
        rsp_idle     = ~rsp_req_q & ~rsp_wait_q;
        rsp_done     = rsp_wait_q & rsp_ack_prev_q & ~uart_rsp_ack;
        bus_idle     = ~wr_req_q & ~rd_req_q & ~bus_wait_q;
        bus_done     = bus_wait_q & bus_ack_prev_q & ~logic_ack;
        last_adr     = bcnt_q == BCNT_W'(P_ADR_BYTES - 1);
        last_dat     = bcnt_q == BCNT_W'(P_DATA_BYTES - 1);
        last_word_wr = (16'(wptr_q) + 16'd1) == len_q;
        last_word_rd = (16'(rptr_q) + 16'd1) == len_q;
        len_full     = {len_q[7:0], uart_cmd_data};
        crc_byte     = (state_q == S_RD_DATA) ? word_q[P_DATA_W-1 -: 8] : uart_cmd_data;
        crc_upd      = crc16_byte(crc_q, crc_byte);
        word_nxt     = P_DATA_W'({word_q, uart_cmd_data});
        tmo_hit      = (state_q != S_IDLE) && (state_q == st_prev_q) &&
                       (tmo_cnt_q == TMO_W'(P_TIMEOUT_CNT_MAX));
        len_err      = rx_vld && (state_q == S_LEN) && (bcnt_q == BCNT_W'(1)) &&
                       ((len_full == 16'd0) || (32'(len_full) > P_MAX_BURST));
        crc_err      = rx_vld && (state_q == S_WR_CRC) && (bcnt_q == BCNT_W'(1)) &&
                       ({crc_hi_q, uart_cmd_data} != crc_q);
        buf_we       = rx_vld && (state_q == S_WR_DATA) && last_dat && !tmo_hit;
        err_set      = {29'd0, tmo_hit, len_err, crc_err};
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[IDX_W'(wptr_q)] <= word_nxt;
    end

    // Error accumulator: a new error in the acknowledge cycle survives the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= '0;
            err_req_q <= 1'b0;
        end else if (err_ack) begin
            err_q     <= err_set;
            err_req_q <= |err_set;
        end else if (|err_set) begin
            err_q     <= err_q | err_set;
            err_req_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            st_prev_q      <= S_IDLE;
            cmd_ack_q      <= 1'b0;
            rsp_req_q      <= 1'b0;
            rsp_wait_q     <= 1'b0;
            rsp_ack_prev_q <= 1'b0;
            rsp_data_q     <= '0;
            wr_req_q       <= 1'b0;
            rd_req_q       <= 1'b0;
            bus_wait_q     <= 1'b0;
            bus_ack_prev_q <= 1'b0;
            adr_q          <= '0;
            wr_data_q      <= '0;
            word_q         <= '0;
            is_burst_q     <= 1'b0;
            is_wr_q        <= 1'b0;
            len_q          <= '0;
            bcnt_q         <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            crc_q          <= 16'hFFFF;
            crc_hi_q       <= '0;
            status_q       <= '0;
            tmo_cnt_q      <= '0;
        end else begin
            rsp_ack_prev_q <= uart_rsp_ack;
            bus_ack_prev_q <= logic_ack;
            st_prev_q      <= state_q;

            if (state_q == S_IDLE || state_q != st_prev_q) tmo_cnt_q <= '0;
            else if (tmo_cnt_q != TMO_W'(P_TIMEOUT_CNT_MAX)) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);

            if (cmd_ack_q) begin
                if (!uart_cmd_req) cmd_ack_q <= 1'b0;
            end else if (uart_cmd_req && rx_state) begin
                cmd_ack_q <= 1'b1;
            end

            // Requests drop as soon as the ack is seen; completion waits for the ack falling edge
            if (rsp_req_q && uart_rsp_ack) begin
                rsp_req_q  <= 1'b0;
                rsp_wait_q <= 1'b1;
            end
            if (rsp_done) rsp_wait_q <= 1'b0;
            if ((wr_req_q || rd_req_q) && logic_ack) begin
                wr_req_q   <= 1'b0;
                rd_req_q   <= 1'b0;
                bus_wait_q <= 1'b1;
            end
            if (bus_done) bus_wait_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    crc_q  <= 16'hFFFF;
                    bcnt_q <= '0;
                    wptr_q <= '0;
                    rptr_q <= '0;
                    if (rx_vld && uart_cmd_data == 8'h8F) state_q <= S_HDR0;
                end
                S_HDR0: if (rx_vld) state_q <= (uart_cmd_data == 8'hC7) ? S_PID1 : S_IDLE;
                S_PID1: if (rx_vld) begin
                    is_burst_q <= uart_cmd_data == 8'h80;
                    state_q    <= (uart_cmd_data == 8'h00 || uart_cmd_data == 8'h80) ? S_PID0 : S_IDLE;
                end
                S_PID0: if (rx_vld) begin
                    is_wr_q <= uart_cmd_data == 8'h01;
                    bcnt_q  <= '0;
                    len_q   <= 16'd1;
                    if (uart_cmd_data != 8'h01 && uart_cmd_data != 8'h02) state_q <= S_IDLE;
                    else                                                  state_q <= is_burst_q ? S_LEN : S_ADR;
                end
                S_LEN: if (rx_vld) begin
                    len_q  <= len_full;
                    bcnt_q <= bcnt_q + BCNT_W'(1);
                    if (bcnt_q == BCNT_W'(1)) begin
                        bcnt_q  <= '0;
                        state_q <= len_err ? S_IDLE : S_ADR;
                    end
                end
                S_ADR: if (rx_vld) begin
                    adr_q  <= P_ADR_W'({adr_q, uart_cmd_data});
                    crc_q  <= crc_upd;
                    bcnt_q <= bcnt_q + BCNT_W'(1);
                    if (last_adr) begin
                        bcnt_q  <= '0;
                        state_q <= is_wr_q ? S_WR_DATA : S_RD_HS;
                    end
                end
                S_WR_DATA: if (rx_vld) begin
                    word_q <= word_nxt;
                    crc_q  <= crc_upd;
                    bcnt_q <= bcnt_q + BCNT_W'(1);
                    if (last_dat) begin
                        bcnt_q <= '0;
                        wptr_q <= wptr_q + CNT_W'(1);
                        if (last_word_wr) state_q <= S_WR_CRC;
                    end
                end
                S_WR_CRC: if (rx_vld) begin
                    crc_hi_q <= uart_cmd_data;
                    bcnt_q   <= bcnt_q + BCNT_W'(1);
                    if (bcnt_q == BCNT_W'(1)) begin
                        bcnt_q <= '0;
                        rptr_q <= '0;
                        if (crc_err) begin
                            status_q <= 8'h01;
                            state_q  <= S_STATUS;
                        end else begin
                            state_q  <= S_WR_COMMIT;
                        end
                    end
                end
                S_WR_COMMIT: begin
                    if (bus_idle) begin
                        wr_req_q  <= 1'b1;
                        wr_data_q <= buf_q[IDX_W'(rptr_q)];
                    end
                    if (bus_done) begin
                        adr_q  <= adr_q + P_ADR_W'(1);
                        rptr_q <= rptr_q + CNT_W'(1);
                        if (last_word_rd) begin
                            status_q <= 8'h00;
                            state_q  <= S_STATUS;
                        end
                    end
                end
                S_STATUS: begin
                    if (rsp_idle) begin
                        rsp_req_q  <= 1'b1;
                        rsp_data_q <= status_q;
                    end
                    if (rsp_done) state_q <= S_IDLE;
                end
                S_RD_HS: begin
                    if (bus_idle) rd_req_q <= 1'b1;
                    if (bus_done) begin
                        word_q  <= logic_rd_data;
                        bcnt_q  <= '0;
                        state_q <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (rsp_idle) begin
                        rsp_req_q  <= 1'b1;
                        rsp_data_q <= word_q[P_DATA_W-1 -: 8];
                        word_q     <= word_q << 8;
                        crc_q      <= crc_upd;
                    end
                    if (rsp_done) begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                        if (last_dat) begin
                            bcnt_q  <= '0;
                            adr_q   <= adr_q + P_ADR_W'(1);
                            rptr_q  <= rptr_q + CNT_W'(1);
                            state_q <= last_word_rd ? S_RD_CRC : S_RD_HS;
                        end
                    end
                end
                S_RD_CRC: begin
                    if (rsp_idle) begin
                        rsp_req_q  <= 1'b1;
                        rsp_data_q <= (bcnt_q == '0) ? crc_q[15:8] : crc_q[7:0];
                    end
                    if (rsp_done) begin
                        bcnt_q <= bcnt_q + BCNT_W'(1);
                        if (bcnt_q == BCNT_W'(1)) begin
                            bcnt_q  <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Stuck too long in one state: drop the packet, keep accumulated errors
            if (tmo_hit) begin
                state_q    <= S_IDLE;
                cmd_ack_q  <= 1'b0;
                rsp_req_q  <= 1'b0;
                rsp_wait_q <= 1'b0;
                wr_req_q   <= 1'b0;
                rd_req_q   <= 1'b0;
                bus_wait_q <= 1'b0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                bcnt_q     <= '0;
            end
        end
    end

    assign uart_cmd_ack  = cmd_ack_q;
    assign uart_rsp_req  = rsp_req_q;
    assign uart_rsp_data = rsp_data_q;
    assign logic_adr     = adr_q;
    assign logic_wr_data = wr_data_q;
    assign logic_wr_req  = wr_req_q;
    assign logic_rd_req  = rd_req_q;
    assign err_out       = err_q;
    assign err_req       = err_req_q;

endmodule
